// File: rtl/sparse_row_encoder_if.sv
// Bus bundle for sparse_row_encoder: dense input stream, compressed value/bitmap
// outputs, frame status and an FSM state debug tap.
interface sparse_row_encoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IF_WIDTH   = 16,
  parameter int CNT_WIDTH  = $clog2(IF_WIDTH) + 1
);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  wr_req_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic                  wr_req_sflag;
  logic [IF_WIDTH-1:0]   wr_data_sflag;
  logic [CNT_WIDTH-1:0]  row_val_num;
  logic                  busy;
  logic                  frame_done;
  logic [1:0]            state_dbg;

  // Input stream: a beat transfers on a rising edge where in_valid && in_ready;
  // the source holds in_data stable until then, and in_ready never waits on in_valid.
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_req_s, wr_data_s, wr_req_sflag, wr_data_sflag,
           row_val_num, busy, frame_done, state_dbg
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_req_s, wr_data_s, wr_req_sflag, wr_data_sflag,
           row_val_num, busy, frame_done, state_dbg
  );
endinterface

// File: rtl/sparse_row_encoder.sv
// Compresses a frame of IF_WIDTH dense rows into nonzero-value strobes plus one
// occupancy bitmap and nonzero count per row.
module sparse_row_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int IF_WIDTH   = 16,
  parameter int CNT_WIDTH  = $clog2(IF_WIDTH) + 1
) (
  input logic                  clk,
  input logic                  reset,
  sparse_row_encoder_if.slave  bus
);
  localparam int COL_W = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST = COL_W'(IF_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FLAG = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [COL_W-1:0]      row_q, row_d;
  logic [IF_WIDTH-1:0]   bmap_q, bmap_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wr_req_s_q, wr_req_s_d;
  logic [DATA_WIDTH-1:0] wr_data_s_q, wr_data_s_d;
  logic                  wr_req_sflag_q, wr_req_sflag_d;
  logic [IF_WIDTH-1:0]   wr_data_sflag_q, wr_data_sflag_d;
  logic [CNT_WIDTH-1:0]  row_val_num_q, row_val_num_d;
  logic                  frame_done_q, frame_done_d;
  logic                  beat_nz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      col_q           <= '0;
      row_q           <= '0;
      bmap_q          <= '0;
      cnt_q           <= '0;
      wr_req_s_q      <= 1'b0;
      wr_data_s_q     <= '0;
      wr_req_sflag_q  <= 1'b0;
      wr_data_sflag_q <= '0;
      row_val_num_q   <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      row_q           <= row_d;
      bmap_q          <= bmap_d;
      cnt_q           <= cnt_d;
      wr_req_s_q      <= wr_req_s_d;
      wr_data_s_q     <= wr_data_s_d;
      wr_req_sflag_q  <= wr_req_sflag_d;
      wr_data_sflag_q <= wr_data_sflag_d;
      row_val_num_q   <= row_val_num_d;
      frame_done_q    <= frame_done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    row_d           = row_q;
    bmap_d          = bmap_q;
    cnt_d           = cnt_q;
    wr_req_s_d      = 1'b0;
    wr_data_s_d     = wr_data_s_q;
    wr_req_sflag_d  = 1'b0;
    wr_data_sflag_d = wr_data_sflag_q;
    row_val_num_d   = row_val_num_q;
    frame_done_d    = 1'b0;
    beat_nz         = (bus.in_data != '0);

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.in_valid) begin
          if (beat_nz) begin
            bmap_d[LAST - col_q] = 1'b1;
            cnt_d                = cnt_q + CNT_WIDTH'(1);
            wr_req_s_d           = 1'b1;
            wr_data_s_d          = bus.in_data;
          end
          // The flag is registered alongside the last beat's strobe so both land in FLAG.
          if (col_q == LAST) begin
            col_d           = '0;
            state_d         = S_FLAG;
            wr_req_sflag_d  = 1'b1;
            wr_data_sflag_d = bmap_d;
            row_val_num_d   = cnt_d;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_FLAG: begin
        bmap_d = '0;
        cnt_d  = '0;
        if (row_q == LAST) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else begin
          row_d   = row_q + COL_W'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready      = (state_q == S_RUN);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.wr_req_s      = wr_req_s_q;
  assign bus.wr_data_s     = wr_data_s_q;
  assign bus.wr_req_sflag  = wr_req_sflag_q;
  assign bus.wr_data_sflag = wr_data_sflag_q;
  assign bus.row_val_num   = row_val_num_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_sparse_row_encoder.sv
// Self-checking bench for sparse_row_encoder: directed rows, random frames with
// and without input gaps, and a mid-frame reset, against a row-level model.
module tb_sparse_row_encoder;
  localparam int DW = 8;
  localparam int IW = 16;
  localparam int CW = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sparse_row_encoder_if #(.DATA_WIDTH(DW), .IF_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  sparse_row_encoder #(.DATA_WIDTH(DW), .IF_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: expected values, bitmaps and counts in emission order
  logic [DW-1:0] exp_q[$];
  logic [IW-1:0] exp_flag_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  logic [IW-1:0] obs_flags[$];
  logic [CW-1:0] obs_cnts[$];
  int            obs_strobes[$];

  logic [DW-1:0] frame_a[IW][IW];
  logic [DW-1:0] frame_b[IW][IW];
  logic [DW-1:0] cur[IW][IW];

  logic          mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row model: bit (IW-1-c) marks a nonzero element in column c
  task automatic push_row_model(input int r);
    logic [IW-1:0] bm;
    int            n;
    bm = '0;
    n  = 0;
    for (int c = 0; c < IW; c++) begin
      if (cur[r][c] != 0) begin
        bm = bm | (IW'(1) << (IW - 1 - c));
        n++;
        exp_q.push_back(cur[r][c]);
      end
    end
    exp_flag_q.push_back(bm);
    exp_cnt_q.push_back(CW'(n));
  endtask

  // Monitor: latency, strobe timing and scoreboard comparisons, sampled mid-cycle
  logic          pend_nz = 1'b0, pend_last = 1'b0, prev_flag = 1'b0, prev_done = 1'b0;
  logic [DW-1:0] pend_data = '0;
  int            acc_cnt = 0, flag_rows = 0, strobe_row = 0;

  always @(negedge clk) begin
    logic acc;
    if (reset) begin
      pend_nz = 1'b0; pend_last = 1'b0; prev_flag = 1'b0; prev_done = 1'b0;
      acc_cnt = 0; flag_rows = 0; strobe_row = 0;
    end else if (mon_en) begin
      check("wr_req_s_latency", bus.wr_req_s, pend_nz);
      if (pend_nz) check("wr_data_s_latency", bus.wr_data_s, pend_data);
      check("wr_req_sflag_timing", bus.wr_req_sflag, pend_last);
      if (bus.wr_req_s) begin
        check("value_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("wr_data_s_value", bus.wr_data_s, exp_q.pop_front());
        strobe_row++;
      end
      if (bus.wr_req_sflag) begin
        check("flag_queue_nonempty", exp_flag_q.size() != 0, 1);
        if (exp_flag_q.size() != 0) begin
          check("wr_data_sflag", bus.wr_data_sflag, exp_flag_q.pop_front());
          check("row_val_num", bus.row_val_num, exp_cnt_q.pop_front());
        end
        obs_flags.push_back(bus.wr_data_sflag);
        obs_cnts.push_back(bus.row_val_num);
        obs_strobes.push_back(strobe_row);
        strobe_row = 0;
        flag_rows++;
      end
      check("frame_done", bus.frame_done, prev_flag && (flag_rows == IW));
      if (prev_done) check("busy_after_done", bus.busy, 0);
      check("in_ready", bus.in_ready, bus.busy && !bus.wr_req_sflag && !bus.frame_done);
      if (bus.frame_done) flag_rows = 0;
      prev_flag = bus.wr_req_sflag;
      prev_done = bus.frame_done;
      acc       = bus.in_valid && bus.in_ready;
      pend_nz   = acc && (bus.in_data != 0);
      pend_data = bus.in_data;
      pend_last = acc && (acc_cnt == IW - 1);
      if (acc) acc_cnt = (acc_cnt == IW - 1) ? 0 : acc_cnt + 1;
    end
  end

  // Driver tasks (entered just after a rising edge)
  task automatic drive_beat(input logic [DW-1:0] d, input int gap);
    logic acc;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("beat_accept_timeout", acc, 1);
  endtask

  task automatic run_frame(input int gmax, input int nrows, input int last_beats);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      int nb;
      nb = (r == nrows - 1) ? last_beats : IW;
      push_row_model(r);
      for (int c = 0; c < nb; c++)
        drive_beat(cur[r][c], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check(tag, bus.busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},      bus.in_ready, 0);
    check({tag, "_busy"},          bus.busy, 0);
    check({tag, "_wr_req_s"},      bus.wr_req_s, 0);
    check({tag, "_wr_data_s"},     bus.wr_data_s, 0);
    check({tag, "_wr_req_sflag"},  bus.wr_req_sflag, 0);
    check({tag, "_wr_data_sflag"}, bus.wr_data_sflag, 0);
    check({tag, "_row_val_num"},   bus.row_val_num, 0);
    check({tag, "_frame_done"},    bus.frame_done, 0);
    check({tag, "_state"},         bus.state_dbg, 0);
  endtask

  function automatic logic [DW-1:0] rand_elem();
    return ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom_range(1, 255));
  endfunction

  initial begin
    logic [IW-1:0] t;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    for (int r = 0; r < IW; r++)
      for (int c = 0; c < IW; c++) begin
        frame_a[r][c] = rand_elem();
        frame_b[r][c] = rand_elem();
      end
    for (int c = 0; c < IW; c++) begin
      frame_a[0][c] = '0;
      frame_a[1][c] = '0;
      frame_a[2][c] = 8'hFF;
    end
    frame_a[0][1]    = 8'h05;
    frame_a[0][4]    = 8'h07;
    frame_a[3][IW-1] = 8'h3C;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed frame, back-to-back with in_valid held high
    cur = frame_a;
    run_frame(0, IW, IW);
    wait_idle("frame_a_end");
    check("frame_a_flag_count", obs_flags.size(), IW);
    check("row0_bitmap", obs_flags[0], 16'h4800);
    check("row0_count", obs_cnts[0], 2);
    check("row0_strobes", obs_strobes[0], 2);
    check("zero_row_bitmap", obs_flags[1], 16'h0000);
    check("zero_row_count", obs_cnts[1], 0);
    check("zero_row_strobes", obs_strobes[1], 0);
    check("ff_row_bitmap", obs_flags[2], 16'hFFFF);
    check("ff_row_count", obs_cnts[2], 16);
    check("ff_row_strobes", obs_strobes[2], 16);
    t = obs_flags[3];
    check("last_3c_bit0", t[0], 1);

    // Same frame with random input gaps, then a fresh random frame
    run_frame(5, IW, IW);
    wait_idle("frame_a_gap_end");
    cur = frame_b;
    run_frame(5, IW, IW);
    wait_idle("frame_b_gap_end");

    // Reset after 7 beats of row 3
    run_frame(1, 4, 7);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    exp_q.delete();
    exp_flag_q.delete();
    exp_cnt_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_reset_busy", bus.busy, 0);
    check("idle_after_reset_state", bus.state_dbg, 0);

    obs_flags.delete();
    cur = frame_a;
    run_frame(2, IW, IW);
    wait_idle("fresh_frame_end");
    check("fresh_flag_count", obs_flags.size(), IW);
    check("fresh_row0_bitmap", obs_flags[0], 16'h4800);

    repeat (3) @(posedge clk);
    check("exp_values_drained", exp_q.size(), 0);
    check("exp_flags_drained", exp_flag_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sparse_row_encoder.md
SPARSE_ROW_ENCODER -- requirements
Module: sparse_row_encoder

Interface
REQ-001: Parameter DATA_WIDTH, default 8, activation element width in bits.
REQ-002: Parameter IF_WIDTH, default 16, elements per row and rows per frame.
REQ-003: Parameter CNT_WIDTH, default C_LOG_2(IF_WIDTH)+1 (5), width of per-row nonzero count.
REQ-004: One clock; reset is asynchronous and active-high.
REQ-005: clk  input  1  clock, all state updates on rising edge.
REQ-006: reset  input  1  asynchronous active-high reset.
REQ-007: start  input  1  single-cycle frame start request.
REQ-008: in_valid  input  1  dense input element valid.
REQ-009: in_data  input  DATA_WIDTH  dense activation element, row-major order, column 0 first.
REQ-010: in_ready  output  1  encoder accepts in_data this cycle.
REQ-011: wr_req_s  output  1  one-cycle strobe, wr_data_s holds a nonzero value.
REQ-012: wr_data_s  output  DATA_WIDTH  compressed nonzero value.
REQ-013: wr_req_sflag  output  1  one-cycle strobe, row bitmap valid.
REQ-014: wr_data_sflag  output  IF_WIDTH  row occupancy bitmap.
REQ-015: row_val_num  output  CNT_WIDTH  nonzero count of the row just flagged.
REQ-016: busy  output  1  high in every state except IDLE.
REQ-017: frame_done  output  1  one-cycle pulse after the last row's flag.

Function
REQ-018: The FSM SHALL have states IDLE, RUN, FLAG and DONE.
REQ-019: IDLE -> RUN on start; start SHALL be ignored outside IDLE.
REQ-020: in_ready SHALL equal (state == RUN); a beat is accepted when in_valid && in_ready.
REQ-021: Column counter col (0..IF_WIDTH-1) SHALL increment per accepted beat and wrap to 0 after IF_WIDTH-1.
REQ-022: Bitmap bit [IF_WIDTH-1-col] SHALL be set to 1 iff the accepted in_data != 0.
- Column 0 maps to the MSB.
REQ-023: Each accepted nonzero beat SHALL drive wr_req_s=1 and wr_data_s=in_data in the following cycle.
- Latency is 1 cycle.
- Zero beats produce no strobe.
REQ-024: When a beat is accepted with col==IF_WIDTH-1, the FSM SHALL enter FLAG.
- In the FLAG cycle, wr_req_sflag=1.
- wr_data_sflag SHALL hold the full bitmap, including the last beat.
- row_val_num SHALL hold the popcount of that bitmap, range 0..IF_WIDTH.
REQ-025: If the last beat is nonzero, its wr_req_s SHALL coincide with the wr_req_sflag cycle.
REQ-026: On leaving FLAG, the working bitmap and count SHALL clear.
- wr_data_sflag and row_val_num SHALL hold their values until the next flag.
REQ-027: Row counter row (0..IF_WIDTH-1) SHALL increment in FLAG.
- FLAG -> RUN if row < IF_WIDTH-1.
- Otherwise FLAG -> DONE.
REQ-028: DONE SHALL last exactly one cycle with frame_done=1, then DONE -> IDLE with row=0 and col=0.
REQ-029: in_valid low in RUN SHALL stall without state change.
- Arbitrary gaps between beats SHALL be tolerated.
REQ-030: in_valid while in_ready=0 SHALL be ignored; the source holds data until acceptance.
REQ-031: wr_req_s, wr_req_sflag and frame_done SHALL never be high for more than one cycle per event.
REQ-032: An all-zero row SHALL produce no wr_req_s, wr_data_sflag=0 and row_val_num=0.
REQ-033: An all-nonzero row SHALL produce IF_WIDTH wr_req_s strobes, wr_data_sflag=all ones and row_val_num=IF_WIDTH.

Reset
REQ-034: While reset=1, all of the following SHALL be 0 and the state SHALL be IDLE:
- state, col, row, working bitmap and count;
- wr_req_s, wr_data_s, wr_req_sflag, wr_data_sflag, row_val_num;
- busy, frame_done, in_ready.
REQ-035: Reset asserted mid-frame SHALL discard the partial row.
- After reset deasserts, no strobe for the discarded row SHALL appear.
- The block waits in IDLE for start.

Verification
REQ-036: Reset release, then start, then one row (IF_WIDTH=16) of 00,05,00,00,07,... followed by zeros -> wr_req_s twice (05, 07), each 1 cycle after acceptance; wr_data_sflag=0100_1000_0000_0000; row_val_num=2.
REQ-037: 16 rows streamed back-to-back with in_valid held high -> in_ready=0 exactly in each FLAG cycle; 16 wr_req_sflag strobes; frame_done 1 cycle after the 16th flag; busy=0 on the following cycle.
REQ-038: Row all 00 -> no wr_req_s; wr_data_sflag=16'h0000; row_val_num=0. Row all FF -> 16 strobes of FF; wr_data_sflag=16'hFFFF; row_val_num=16.
REQ-039: Last beat of a row = 3C -> wr_req_s (3C) and wr_req_sflag are asserted in the same cycle, and bit 0 of the bitmap is 1.
REQ-040: Random in_valid gaps (0-5 idle cycles) -> bitmaps, values and counts identical to the gap-free run.
REQ-041: Reset pulsed after 7 beats of row 3 -> all outputs 0 during reset; no stale strobe after it; start then delivers a fresh frame from row 0 with correct bitmaps.
